// File: rtl/sprite_layer.sv
// Sprite layer: pixel responder that draws a 16x16 1-bit plane sprite over a flat background.
// Latency: 2 cycles from request (h, v, disp) to registered RGB; the position path commits once per frame.
// Backpressure: pos_ready_o drops while a position is pending and returns the cycle after the frame commit.
//
// Ports:
//   clk, rst                     pixel clock, synchronous active-high reset
//   req_h_addr_i/req_v_addr_i    requested column/row, disp_i marks the active area
//   v_sync_i                     vertical sync (active low); its registered falling edge is the commit event
//   pos_valid_i/pos_ready_o      handshake for a new sprite position pos_x_i/pos_y_i
//   hit_i                        one-cycle hit pulse (used only with SPRITE_HIT_FLASH_EN)
//   vga_r_o/vga_g_o/vga_b_o      registered colour, frame_o pulses on every commit event
// Optional feature: define SPRITE_HIT_FLASH_EN to blink the sprite for FLASH_FRAMES frames after a hit.

`ifndef H_DISP_LEN
`define H_DISP_LEN 10
`endif
`ifndef V_DISP_LEN
`define V_DISP_LEN 10
`endif
`ifndef COLOR_R_DEPTH
`define COLOR_R_DEPTH 4
`endif
`ifndef COLOR_G_DEPTH
`define COLOR_G_DEPTH 4
`endif
`ifndef COLOR_B_DEPTH
`define COLOR_B_DEPTH 4
`endif
`ifndef BG_COLOR_R
`define BG_COLOR_R 4'h1
`endif
`ifndef BG_COLOR_G
`define BG_COLOR_G 4'h2
`endif
`ifndef BG_COLOR_B
`define BG_COLOR_B 4'h6
`endif

module sprite_layer #(
   parameter int unsigned SPR_W        = 16,
   parameter int unsigned SPR_H        = 16,
   parameter int unsigned H_ACTIVE     = 640,
   parameter int unsigned V_ACTIVE     = 480,
   parameter int unsigned INIT_X       = 312,
   parameter int unsigned INIT_Y       = 440,
   parameter int unsigned FLASH_FRAMES = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [`H_DISP_LEN-1:0]    req_h_addr_i,
   input  logic [`V_DISP_LEN-1:0]    req_v_addr_i,
   input  logic                      disp_i,
   input  logic                      v_sync_i,
   input  logic                      pos_valid_i,
   output logic                      pos_ready_o,
   input  logic [`H_DISP_LEN-1:0]    pos_x_i,
   input  logic [`V_DISP_LEN-1:0]    pos_y_i,
   input  logic                      hit_i,
   output logic [`COLOR_R_DEPTH-1:0] vga_r_o,
   output logic [`COLOR_G_DEPTH-1:0] vga_g_o,
   output logic [`COLOR_B_DEPTH-1:0] vga_b_o,
   output logic                      frame_o
);

   localparam int HW = `H_DISP_LEN;
   localparam int VW = `V_DISP_LEN;
   localparam logic [HW-1:0] X_MAX = HW'(H_ACTIVE - SPR_W);
   localparam logic [VW-1:0] Y_MAX = VW'(V_ACTIVE - SPR_H);

   // ------------------------------------------------------------------
   // Position handshake and frame commit
   // ------------------------------------------------------------------
   logic          vs_q, commit_q;
   logic          pending_q, pending_d;
   logic [HW-1:0] sx_q, sx_d, x_q, x_d;
   logic [VW-1:0] sy_q, sy_d, y_q, y_d;
   logic          xfer;

   assign pos_ready_o = !pending_q;
   assign frame_o     = commit_q;
   assign xfer        = pos_valid_i && !pending_q;

   always_comb begin
      pending_d = pending_q;
      sx_d      = sx_q;
      sy_d      = sy_q;
      x_d       = x_q;
      y_d       = y_q;
      // Commit consumes only what was pending before this edge; a position
      // transferred on the commit cycle waits for the next frame.
      if (commit_q && pending_q) begin
         x_d       = sx_q;
         y_d       = sy_q;
         pending_d = 1'b0;
      end
      if (xfer) begin
         sx_d      = (pos_x_i > X_MAX) ? X_MAX : pos_x_i;
         sy_d      = (pos_y_i > Y_MAX) ? Y_MAX : pos_y_i;
         pending_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vs_q      <= 1'b1;
         commit_q  <= 1'b0;
         pending_q <= 1'b0;
         sx_q      <= HW'(INIT_X);
         sy_q      <= VW'(INIT_Y);
         x_q       <= HW'(INIT_X);
         y_q       <= VW'(INIT_Y);
      end else begin
         vs_q      <= v_sync_i;
         commit_q  <= vs_q && !v_sync_i;
         pending_q <= pending_d;
         sx_q      <= sx_d;
         sy_q      <= sy_d;
         x_q       <= x_d;
         y_q       <= y_d;
      end
   end

   // ------------------------------------------------------------------
   // Hit flash
   // ------------------------------------------------------------------
   logic visible;

`ifdef SPRITE_HIT_FLASH_EN
   localparam int CW = $clog2(FLASH_FRAMES + 1);
   logic [CW-1:0] flash_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         flash_q <= '0;
      end else if (hit_i) begin
         flash_q <= CW'(FLASH_FRAMES);
      end else if (commit_q && (flash_q != '0)) begin
         flash_q <= flash_q - 1'b1;
      end
   end

   // Blank on odd counts so the sprite toggles once per frame.
   assign visible = (flash_q == '0) || !flash_q[0];
`else
   logic unused_flash;
   assign unused_flash = ^{hit_i, 32'(FLASH_FRAMES)};
   assign visible      = 1'b1;
`endif

   // ------------------------------------------------------------------
   // Pixel pipeline, stage 1: box test and sprite-local coordinates
   // ------------------------------------------------------------------
   // One extra bit keeps x+SPR_W from wrapping back to column 0.
   logic [HW:0] h_ext, x_lo, x_hi;
   logic [VW:0] v_ext, y_lo, y_hi;
   logic        in_box_d;
   logic [3:0]  dx_d, dy_d;

   assign h_ext    = {1'b0, req_h_addr_i};
   assign x_lo     = {1'b0, x_q};
   assign x_hi     = x_lo + (HW+1)'(SPR_W);
   assign v_ext    = {1'b0, req_v_addr_i};
   assign y_lo     = {1'b0, y_q};
   assign y_hi     = y_lo + (VW+1)'(SPR_H);
   assign in_box_d = (h_ext >= x_lo) && (h_ext < x_hi) && (v_ext >= y_lo) && (v_ext < y_hi);
   assign dx_d     = req_h_addr_i[3:0] - x_q[3:0];
   assign dy_d     = req_v_addr_i[3:0] - y_q[3:0];

   logic       disp_q, in_box_q;
   logic [3:0] dx_q, dy_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         disp_q   <= 1'b0;
         in_box_q <= 1'b0;
         dx_q     <= '0;
         dy_q     <= '0;
      end else begin
         disp_q   <= disp_i;
         in_box_q <= in_box_d;
         dx_q     <= dx_d;
         dy_q     <= dy_d;
      end
   end

   // ------------------------------------------------------------------
   // Pixel pipeline, stage 2: shape ROM and colour select
   // ------------------------------------------------------------------
   // Row bit 15 is the leftmost column of the sprite.
   function automatic logic [15:0] rom_row(input logic [3:0] r);
      case (r)
         4'd0:    rom_row = 16'h0180;
         4'd1:    rom_row = 16'h0180;
         4'd2:    rom_row = 16'h03C0;
         4'd3:    rom_row = 16'h03C0;
         4'd4:    rom_row = 16'h07E0;
         4'd5:    rom_row = 16'h0FF0;
         4'd6:    rom_row = 16'h3FFC;
         4'd7:    rom_row = 16'hFFFF;
         4'd8:    rom_row = 16'hFFFF;
         4'd9:    rom_row = 16'h07E0;
         4'd10:   rom_row = 16'h03C0;
         4'd11:   rom_row = 16'h03C0;
         4'd12:   rom_row = 16'h0FF0;
         4'd13:   rom_row = 16'h1FF8;
         4'd14:   rom_row = 16'h1998;
         default: rom_row = 16'h0000;
      endcase
   endfunction

   logic [15:0] row_bits;
   logic        pix_bit;

   assign row_bits = rom_row(dy_q);
   assign pix_bit  = row_bits[4'd15 - dx_q];

   always_ff @(posedge clk) begin
      if (rst || !disp_q) begin
         vga_r_o <= '0;
         vga_g_o <= '0;
         vga_b_o <= '0;
      end else if (in_box_q && pix_bit && visible) begin
         vga_r_o <= '1;
         vga_g_o <= '0;
         vga_b_o <= '0;
      end else begin
         vga_r_o <= `BG_COLOR_R;
         vga_g_o <= `BG_COLOR_G;
         vga_b_o <= `BG_COLOR_B;
      end
   end

endmodule

// File: tb/tb_sprite_layer.sv
// Directed bench for sprite_layer: reset state, pipeline latency, shape and box edges,
// frame-synchronous position commit, clamping, commit/transfer collision, reset mid-frame, hit flash.

`ifndef H_DISP_LEN
`define H_DISP_LEN 10
`endif
`ifndef V_DISP_LEN
`define V_DISP_LEN 10
`endif
`ifndef COLOR_R_DEPTH
`define COLOR_R_DEPTH 4
`endif
`ifndef COLOR_G_DEPTH
`define COLOR_G_DEPTH 4
`endif
`ifndef COLOR_B_DEPTH
`define COLOR_B_DEPTH 4
`endif
`ifndef BG_COLOR_R
`define BG_COLOR_R 4'h1
`endif
`ifndef BG_COLOR_G
`define BG_COLOR_G 4'h2
`endif
`ifndef BG_COLOR_B
`define BG_COLOR_B 4'h6
`endif

module tb_sprite_layer;

   localparam int RW = `COLOR_R_DEPTH;
   localparam int GW = `COLOR_G_DEPTH;
   localparam int BW = `COLOR_B_DEPTH;
   localparam int CW = RW + GW + BW;

   localparam logic [CW-1:0] SPR = {{RW{1'b1}}, {GW{1'b0}}, {BW{1'b0}}};
   localparam logic [CW-1:0] BG  = {RW'(`BG_COLOR_R), GW'(`BG_COLOR_G), BW'(`BG_COLOR_B)};
   localparam logic [CW-1:0] BLK = '0;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [`H_DISP_LEN-1:0]  req_h_addr_i;
   logic [`V_DISP_LEN-1:0]  req_v_addr_i;
   logic                    disp_i;
   logic                    v_sync_i;
   logic                    pos_valid_i;
   logic                    pos_ready_o;
   logic [`H_DISP_LEN-1:0]  pos_x_i;
   logic [`V_DISP_LEN-1:0]  pos_y_i;
   logic                    hit_i;
   logic [RW-1:0]           vga_r_o;
   logic [GW-1:0]           vga_g_o;
   logic [BW-1:0]           vga_b_o;
   logic                    frame_o;

   int tests = 0;
   int fails = 0;

   sprite_layer dut (
      .clk          (clk),
      .rst          (rst),
      .req_h_addr_i (req_h_addr_i),
      .req_v_addr_i (req_v_addr_i),
      .disp_i       (disp_i),
      .v_sync_i     (v_sync_i),
      .pos_valid_i  (pos_valid_i),
      .pos_ready_o  (pos_ready_o),
      .pos_x_i      (pos_x_i),
      .pos_y_i      (pos_y_i),
      .hit_i        (hit_i),
      .vga_r_o      (vga_r_o),
      .vga_g_o      (vga_g_o),
      .vga_b_o      (vga_b_o),
      .frame_o      (frame_o)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rgb(input string tag, input logic [CW-1:0] exp);
      logic [CW-1:0] obs;
      obs = {vga_r_o, vga_g_o, vga_b_o};
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: rgb observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_bit(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Present a request, hold it for two edges, then check the colour.
   task automatic pix(input string tag, input int h, input int v, input logic d, input logic [CW-1:0] exp);
      req_h_addr_i = `H_DISP_LEN'(h);
      req_v_addr_i = `V_DISP_LEN'(v);
      disp_i       = d;
      step();
      step();
      chk_rgb(tag, exp);
   endtask

   // One v_sync low pulse: the commit cycle follows the sampled fall.
   task automatic vsync(input string tag);
      v_sync_i = 1'b0;
      step();
      chk_bit({tag, "_frame_hi"}, frame_o, 1'b1);
      v_sync_i = 1'b1;
      step();
      chk_bit({tag, "_frame_lo"}, frame_o, 1'b0);
   endtask

   task automatic offer(input int x, input int y);
      pos_valid_i = 1'b1;
      pos_x_i     = `H_DISP_LEN'(x);
      pos_y_i     = `V_DISP_LEN'(y);
      step();
      pos_valid_i = 1'b0;
   endtask

   initial begin
      rst          = 1'b1;
      req_h_addr_i = '0;
      req_v_addr_i = '0;
      disp_i       = 1'b0;
      v_sync_i     = 1'b1;
      pos_valid_i  = 1'b0;
      pos_x_i      = '0;
      pos_y_i      = '0;
      hit_i        = 1'b0;
      step();
      step();
      step();

      // Reset state
      chk_rgb("rst_rgb", BLK);
      chk_bit("rst_ready", pos_ready_o, 1'b1);
      chk_bit("rst_frame", frame_o, 1'b0);
      rst = 1'b0;

      // First pixel is background
      pix("t1_bg_0_0", 0, 0, 1'b1, BG);
      chk_bit("t1_ready", pos_ready_o, 1'b1);
      chk_bit("t1_frame", frame_o, 1'b0);

      // Latency is exactly two edges
      req_h_addr_i = 10'd319;
      req_v_addr_i = 10'd447;
      disp_i       = 1'b1;
      step();
      chk_rgb("lat_edge1", BG);
      step();
      chk_rgb("lat_edge2", SPR);

      // Shape and box edges at the reset position (312,440)
      pix("t2_corner_tl", 312, 440, 1'b1, BG);
      pix("t2_row0_mid", 319, 440, 1'b1, SPR);
      pix("t2_row7_left", 312, 447, 1'b1, SPR);
      pix("t2_row8_right", 327, 448, 1'b1, SPR);
      pix("t2_right_out", 328, 448, 1'b1, BG);
      pix("t2_left_out", 311, 447, 1'b1, BG);
      pix("t2_row15", 319, 455, 1'b1, BG);
      pix("t2_below", 319, 456, 1'b1, BG);
      pix("t2_above", 319, 439, 1'b1, BG);
      pix("t2_row14_dx3", 315, 454, 1'b1, SPR);
      pix("t2_row14_dx5", 317, 454, 1'b1, BG);
      pix("t2_nodisp", 319, 447, 1'b0, BLK);

      // Mid-frame transfer only takes effect after the v_sync fall
      offer(100, 50);
      chk_bit("t3_ready_lo", pos_ready_o, 1'b0);
      pix("t3_old_pos", 312, 447, 1'b1, SPR);
      pix("t3_new_not_yet", 100, 57, 1'b1, BG);
      v_sync_i = 1'b0;
      step();
      chk_bit("t3_frame_hi", frame_o, 1'b1);
      chk_bit("t3_ready_still_lo", pos_ready_o, 1'b0);
      v_sync_i = 1'b1;
      step();
      chk_bit("t3_frame_lo", frame_o, 1'b0);
      chk_bit("t3_ready_back", pos_ready_o, 1'b1);
      pix("t3_new_pos", 100, 57, 1'b1, SPR);
      pix("t3_new_end", 115, 57, 1'b1, SPR);
      pix("t3_old_gone", 312, 447, 1'b1, BG);

      // Transfer on the commit cycle is deferred to the following frame
      v_sync_i = 1'b0;
      step();
      chk_bit("t5_frame_hi", frame_o, 1'b1);
      chk_bit("t5_ready_hi", pos_ready_o, 1'b1);
      v_sync_i = 1'b1;
      offer(200, 100);
      chk_bit("t5_pending", pos_ready_o, 1'b0);
      pix("t5_unchanged", 100, 57, 1'b1, SPR);
      pix("t5_not_applied", 200, 107, 1'b1, BG);
      vsync("t5_next");
      pix("t5_applied", 200, 107, 1'b1, SPR);
      chk_bit("t5_ready_back", pos_ready_o, 1'b1);

      // Clamp to (624,464): hugs the corner, no wrap into column 0
      offer(700, 470);
      vsync("t4");
      pix("t4_corner_br", 639, 471, 1'b1, SPR);
      pix("t4_row0", 631, 464, 1'b1, SPR);
      pix("t4_left_out", 623, 471, 1'b1, BG);
      pix("t4_no_wrap", 0, 471, 1'b1, BG);
      pix("t4_no_wrap_x15", 15, 471, 1'b1, BG);

      // Reset while a sprite pixel is in flight
      req_h_addr_i = 10'd639;
      req_v_addr_i = 10'd471;
      disp_i       = 1'b1;
      step();
      rst = 1'b1;
      step();
      chk_rgb("rstmid_black", BLK);
      rst = 1'b0;
      pix("rstmid_old_gone", 639, 471, 1'b1, BG);
      pix("rstmid_init_pos", 312, 447, 1'b1, SPR);

`ifdef SPRITE_HIT_FLASH_EN
      // Counter walks 8..0, sprite hidden on odd counts
      hit_i = 1'b1;
      step();
      hit_i = 1'b0;
      pix("flash_k0", 312, 447, 1'b1, SPR);
      for (int k = 1; k <= 9; k++) begin
         int cnt;
         cnt = (k <= 8) ? 8 - k : 0;
         vsync($sformatf("flash_c%0d", k));
         pix($sformatf("flash_k%0d", k), 312, 447, 1'b1, (cnt % 2 == 0) ? SPR : BG);
      end
      // Hit on the commit cycle: reload wins over decrement
      hit_i = 1'b1;
      step();
      hit_i    = 1'b0;
      v_sync_i = 1'b0;
      step();
      chk_bit("flash_coll_frame", frame_o, 1'b1);
      hit_i    = 1'b1;
      v_sync_i = 1'b1;
      step();
      hit_i = 1'b0;
      pix("flash_coll_reload", 312, 447, 1'b1, SPR);
      vsync("flash_after_coll");
      pix("flash_after_coll_hidden", 312, 447, 1'b1, BG);
`else
      // Hit is ignored without the flash feature
      hit_i = 1'b1;
      step();
      hit_i = 1'b0;
      pix("nohit_k0", 312, 447, 1'b1, SPR);
      vsync("nohit_c1");
      pix("nohit_k1", 312, 447, 1'b1, SPR);
      vsync("nohit_c2");
      pix("nohit_k2", 312, 447, 1'b1, SPR);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
